// File: rtl/md6_cf_sequencer.sv
// Sequences one MD6 compression: accept job, hold fields, load core, step 16*R times, capture C.
// Latency: cf_load 1 cycle after accept, steps in cycles 2..S+1, out_valid first high at cycle S+3.
// Backpressure: single job in flight; in_ready low until the result is taken; out_valid holds until out_ready.
module md6_cf_sequencer #(
  parameter int W      = 64,
  parameter int CW     = 16,
  parameter int STEP_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_level,
  input  logic [55:0]         in_index,
  input  logic [3:0]          in_z,
  input  logic [64*W-1:0]     in_M,
  input  logic [11:0]         cfg_r,
  input  logic [11:0]         cfg_d,
  output logic [7:0]          n_level,
  output logic [55:0]         n_index,
  output logic [3:0]          n_z,
  output logic [64*W-1:0]     n_M,
  output logic [11:0]         n_r,
  output logic [11:0]         n_d,
  output logic                cf_load,
  output logic                cf_step,
  output logic [STEP_W-1:0]   step_idx,
  input  logic [CW*W-1:0]     cf_C,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW*W-1:0]     out_C,
  output logic [7:0]          out_level,
  output logic [55:0]         out_index,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0]      level;
    logic [55:0]     index;
    logic [3:0]      z;
    logic [64*W-1:0] msg;
    logic [11:0]     r;
    logic [11:0]     d;
  } job_t;

  state_t            state;
  job_t              job_q;
  logic [STEP_W-1:0] step_last;
  logic [11:0]       r_eff;
  logic [STEP_W-1:0] step_total;
  logic              accept;

  // Default round count grows with digest size; cfg_d>>2 is at most 1023 so 12 bits suffice.
  assign r_eff      = (cfg_r == 12'd0) ? (12'd40 + {2'b00, cfg_d[11:2]}) : cfg_r;
  assign step_total = STEP_W'({r_eff, 4'b0000});
  assign accept     = in_valid && in_ready;

  assign n_level = job_q.level;
  assign n_index = job_q.index;
  assign n_z     = job_q.z;
  assign n_M     = job_q.msg;
  assign n_r     = job_q.r;
  assign n_d     = job_q.d;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      job_q     <= '0;
      step_last <= '0;
      in_ready  <= 1'b0;
      cf_load   <= 1'b0;
      cf_step   <= 1'b0;
      step_idx  <= '0;
      out_valid <= 1'b0;
      out_C     <= '0;
      out_level <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            job_q.level <= in_level;
            job_q.index <= in_index;
            job_q.z     <= in_z;
            job_q.msg   <= in_M;
            job_q.r     <= r_eff;
            job_q.d     <= cfg_d;
            step_last   <= step_total - STEP_W'(1);
            in_ready    <= 1'b0;
            cf_load     <= 1'b1;
            state       <= S_LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          cf_load  <= 1'b0;
          cf_step  <= 1'b1;
          step_idx <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (step_idx == step_last) begin
            cf_step  <= 1'b0;
            step_idx <= '0;
            state    <= S_CAPT;
          end else begin
            step_idx <= step_idx + STEP_W'(1);
          end
        end
        S_CAPT: begin
          out_C     <= cf_C;
          out_level <= job_q.level;
          out_index <= job_q.index;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          // Re-arm in_ready in the handshake edge so a new job can land the next cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_load_step_excl: assert property (@(posedge clk) disable iff (rst) !(cf_load && cf_step));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_C)));
  a_ready_idle: assert property (@(posedge clk) disable iff (rst) in_ready |-> !busy);

endmodule

// File: tb/tb_md6_cf_sequencer.sv
// Randomized self-checking bench for md6_cf_sequencer against a round-count/latency reference model.
module tb_md6_cf_sequencer;
  localparam int W = 64, CW = 16, STEP_W = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cf_load, cf_step, out_valid, out_ready, busy;
  logic [7:0] in_level, n_level, out_level;
  logic [55:0] in_index, n_index, out_index;
  logic [3:0] in_z, n_z;
  logic [64*W-1:0] in_M, n_M;
  logic [11:0] cfg_r, cfg_d, n_r, n_d;
  logic [STEP_W-1:0] step_idx;
  logic [CW*W-1:0] cf_C, out_C;

  int checks = 0, fails = 0;
  // Monitor counters
  int load_cnt, step_cnt, seq_err, excl_err, max_idx, exp_idx;
  // Observations from the last job
  int valid_cycle, acc_wait, stab_err;
  logic obs_load1, obs_ready1, valid_after, ready_after;
  logic [7:0] obs_n_level, obs_out_level, obs_n_end;
  logic [55:0] obs_n_index, obs_out_index;
  logic [3:0] obs_n_z;
  logic [11:0] obs_n_r, obs_n_d;
  logic [64*W-1:0] obs_n_M, job_M;
  logic [CW*W-1:0] exp_C, obs_C;

  md6_cf_sequencer #(.W(W), .CW(CW), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_level(in_level), .in_index(in_index), .in_z(in_z), .in_M(in_M),
    .cfg_r(cfg_r), .cfg_d(cfg_d),
    .n_level(n_level), .n_index(n_index), .n_z(n_z), .n_M(n_M), .n_r(n_r), .n_d(n_d),
    .cf_load(cf_load), .cf_step(cf_step), .step_idx(step_idx), .cf_C(cf_C),
    .out_valid(out_valid), .out_ready(out_ready), .out_C(out_C),
    .out_level(out_level), .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (cf_load) begin
      load_cnt++;
      exp_idx = 0;
    end
    if (cf_load && cf_step) excl_err++;
    if (cf_step) begin
      if (int'(step_idx) != exp_idx) seq_err++;
      max_idx = int'(step_idx);
      step_cnt++;
      exp_idx++;
    end
  end

  function automatic int model_rounds(input int r, input int d);
    return (r == 0) ? 40 + d / 4 : r;
  endfunction

  function automatic logic [64*W-1:0] rand_M();
    logic [64*W-1:0] v;
    for (int i = 0; i < 64*W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [CW*W-1:0] rand_C();
    logic [CW*W-1:0] v;
    for (int i = 0; i < CW*W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one job from a negedge and records what the DUT did; the caller judges it.
  task automatic run_job(input logic [7:0] lvl, input logic [55:0] idx, input logic [3:0] z,
                         input logic [11:0] r, input logic [11:0] d,
                         input int ready_delay, input bit hold_valid);
    int s, lim;
    job_M = rand_M();
    in_level = lvl; in_index = idx; in_z = z; in_M = job_M;
    cfg_r = r; cfg_d = d; in_valid = 1'b1;
    out_ready = (ready_delay == 0);
    load_cnt = 0; step_cnt = 0; seq_err = 0; excl_err = 0; max_idx = -1;
    valid_cycle = -1; acc_wait = 0; stab_err = 0; valid_after = 1'b1; ready_after = 1'b0;
    while (!in_ready && acc_wait < 100) begin
      @(negedge clk);
      acc_wait++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    s = 16 * model_rounds(int'(r), int'(d));
    @(negedge clk);
    if (hold_valid) begin
      in_level = ~lvl; in_index = ~idx; in_z = ~z;
    end else begin
      in_valid = 1'b0;
    end
    obs_load1 = cf_load; obs_ready1 = in_ready;
    obs_n_level = n_level; obs_n_index = n_index; obs_n_z = n_z;
    obs_n_M = n_M; obs_n_r = n_r; obs_n_d = n_d;
    lim = s + 23;
    for (int c = 1; c <= lim; c++) begin
      cf_C = rand_C();
      if (c == s + 2) exp_C = cf_C;
      if (c == 5) begin
        cfg_r = r ^ 12'hA5A;
        cfg_d = d ^ 12'h3C3;
      end
      if (out_valid) begin
        valid_cycle = c;
        break;
      end
      @(negedge clk);
    end
    if (valid_cycle < 0) begin
      out_ready = 1'b0;
      in_valid = 1'b0;
      return;
    end
    obs_C = out_C; obs_out_level = out_level; obs_out_index = out_index; obs_n_end = n_level;
    repeat (ready_delay) begin
      @(negedge clk);
      if (!out_valid || out_C !== obs_C || out_level !== obs_out_level ||
          out_index !== obs_out_index || in_ready) stab_err++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    valid_after = out_valid; ready_after = in_ready;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cf_C = '0;
    in_level = '0; in_index = '0; in_z = '0; in_M = '0; cfg_r = '0; cfg_d = '0;
    repeat (3) @(negedge clk);
    checks++; if ({in_ready, cf_load, cf_step, out_valid, busy} !== 5'b0) begin
      fails++; $display("FAIL reset ctrl: got %b want 00000", {in_ready, cf_load, cf_step, out_valid, busy}); end
    checks++; if (step_idx !== '0) begin
      fails++; $display("FAIL reset step_idx: got %0d want 0", step_idx); end
    checks++; if (out_C !== '0 || out_level !== 8'd0 || out_index !== 56'd0) begin
      fails++; $display("FAIL reset out: got C=%h lvl=%h idx=%h want 0", out_C[63:0], out_level, out_index); end
    checks++; if (n_level !== 8'd0 || n_index !== 56'd0 || n_z !== 4'd0 || n_r !== 12'd0 ||
                  n_d !== 12'd0 || n_M !== '0) begin
      fails++; $display("FAIL reset n_fields: got lvl=%h r=%0d d=%0d want 0", n_level, n_r, n_d); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset release: got in_ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_default_rounds();
    run_job(8'($urandom), {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd0, 12'd256, 0, 1'b0);
    checks++; if (obs_n_r !== 12'd104 || obs_n_d !== 12'd256) begin
      fails++; $display("FAIL default n_r/n_d: got %0d/%0d want 104/256", obs_n_r, obs_n_d); end
    checks++; if (obs_load1 !== 1'b1 || obs_ready1 !== 1'b0) begin
      fails++; $display("FAIL default cycle1: got load=%b ready=%b want 1 0", obs_load1, obs_ready1); end
    checks++; if (step_cnt != 1664 || max_idx != 1663 || seq_err != 0) begin
      fails++; $display("FAIL default steps: got cnt=%0d last=%0d seqerr=%0d want 1664 1663 0", step_cnt, max_idx, seq_err); end
    checks++; if (valid_cycle != 1667) begin
      fails++; $display("FAIL default latency: got %0d want 1667", valid_cycle); end
    checks++; if (obs_C !== exp_C) begin
      fails++; $display("FAIL default out_C: got %h want %h", obs_C[63:0], exp_C[63:0]); end
    checks++; if (valid_after !== 1'b0 || ready_after !== 1'b1) begin
      fails++; $display("FAIL default handshake: got valid=%b ready=%b want 0 1", valid_after, ready_after); end
  endtask

  task automatic test_explicit_rounds();
    run_job(8'($urandom), {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd1, 12'd512, 0, 1'b0);
    checks++; if (obs_n_r !== 12'd1 || obs_n_d !== 12'd512) begin
      fails++; $display("FAIL explicit n_r/n_d: got %0d/%0d want 1/512", obs_n_r, obs_n_d); end
    checks++; if (load_cnt != 1 || excl_err != 0) begin
      fails++; $display("FAIL explicit load: got loads=%0d overlap=%0d want 1 0", load_cnt, excl_err); end
    checks++; if (step_cnt != 16 || max_idx != 15) begin
      fails++; $display("FAIL explicit steps: got %0d last=%0d want 16 15", step_cnt, max_idx); end
    checks++; if (valid_cycle != 19) begin
      fails++; $display("FAIL explicit latency: got %0d want 19", valid_cycle); end
  endtask

  task automatic test_field_capture();
    logic [11:0] r;
    r = 12'($urandom_range(2, 6));
    run_job(8'h01, 56'h5, 4'h1, r, 12'($urandom), 0, 1'b0);
    checks++; if (obs_out_level !== 8'h01 || obs_out_index !== 56'h5) begin
      fails++; $display("FAIL capture lvl/idx: got %h/%h want 01/5", obs_out_level, obs_out_index); end
    checks++; if (obs_n_z !== 4'h1 || obs_n_M !== job_M) begin
      fails++; $display("FAIL capture n_z/n_M: got %h/%h want 1/%h", obs_n_z, obs_n_M[63:0], job_M[63:0]); end
    checks++; if (obs_C !== exp_C) begin
      fails++; $display("FAIL capture out_C: got %h want %h", obs_C[63:0], exp_C[63:0]); end
    checks++; if (step_cnt != 16 * int'(r)) begin
      fails++; $display("FAIL capture cfg_change steps: got %0d want %0d", step_cnt, 16 * int'(r)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lvl_a, lvl_b;
    lvl_a = 8'($urandom); lvl_b = 8'($urandom);
    run_job(lvl_a, {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd1, 12'd0, 50, 1'b1);
    checks++; if (stab_err != 0) begin
      fails++; $display("FAIL backpressure hold: got %0d unstable cycles want 0", stab_err); end
    checks++; if (obs_n_end !== lvl_a) begin
      fails++; $display("FAIL backpressure n_level: got %h want %h", obs_n_end, lvl_a); end
    checks++; if (valid_after !== 1'b0 || ready_after !== 1'b1) begin
      fails++; $display("FAIL backpressure release: got valid=%b ready=%b want 0 1", valid_after, ready_after); end
    run_job(lvl_b, {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd3, 12'd0, 0, 1'b0);
    checks++; if (acc_wait != 0 || obs_n_level !== lvl_b) begin
      fails++; $display("FAIL back_to_back accept: got wait=%0d lvl=%h want 0 %h", acc_wait, obs_n_level, lvl_b); end
    checks++; if (step_cnt != 48 || valid_cycle != 51) begin
      fails++; $display("FAIL back_to_back job: got steps=%0d lat=%0d want 48 51", step_cnt, valid_cycle); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    found = 1'b0;
    in_level = 8'($urandom); in_index = {24'($urandom), 32'($urandom)}; in_z = 4'($urandom);
    in_M = rand_M(); cfg_r = 12'd20; cfg_d = 12'd0; in_valid = 1'b1; out_ready = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (cf_load) in_valid = 1'b0;
      if (cf_step && step_idx == STEP_W'(300)) begin
        found = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++; if (!found) begin
      fails++; $display("FAIL reset_mid_run reach: got no step 300 want step 300 within 1000 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({cf_step, cf_load, out_valid, busy, in_ready} !== 5'b0 || step_idx !== '0) begin
      fails++; $display("FAIL reset_mid_run ctrl: got %b idx=%0d want 00000 0", {cf_step, cf_load, out_valid, busy, in_ready}, step_idx); end
    checks++; if (n_r !== 12'd0 || n_level !== 8'd0 || n_M !== '0) begin
      fails++; $display("FAIL reset_mid_run n_fields: got r=%0d lvl=%h want 0 0", n_r, n_level); end
    step_cnt = 0; load_cnt = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (step_cnt != 0 || load_cnt != 0) begin
      fails++; $display("FAIL reset_mid_run quiet: got steps=%0d loads=%0d want 0 0", step_cnt, load_cnt); end
    run_job(8'($urandom), {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd1, 12'd0, 0, 1'b0);
    checks++; if (step_cnt != 16 || max_idx != 15 || seq_err != 0 || valid_cycle != 19) begin
      fails++; $display("FAIL reset_mid_run restart: got steps=%0d last=%0d seqerr=%0d lat=%0d want 16 15 0 19", step_cnt, max_idx, seq_err, valid_cycle); end
  endtask

  task automatic test_max_rounds();
    run_job(8'($urandom), {24'($urandom), 32'($urandom)}, 4'($urandom), 12'd4095, 12'($urandom), 0, 1'b0);
    checks++; if (obs_n_r !== 12'd4095) begin
      fails++; $display("FAIL max n_r: got %0d want 4095", obs_n_r); end
    checks++; if (step_cnt != 65520 || max_idx != 65519 || seq_err != 0) begin
      fails++; $display("FAIL max steps: got cnt=%0d last=%0d seqerr=%0d want 65520 65519 0", step_cnt, max_idx, seq_err); end
    checks++; if (valid_cycle != 65523) begin
      fails++; $display("FAIL max latency: got %0d want 65523", valid_cycle); end
  endtask

  task automatic test_random_jobs();
    logic [7:0] lvl;
    logic [55:0] idx;
    logic [3:0] z;
    logic [11:0] r, d;
    int rr;
    for (int j = 0; j < 5; j++) begin
      lvl = 8'($urandom); idx = {24'($urandom), 32'($urandom)}; z = 4'($urandom);
      r = 12'($urandom_range(0, 10));
      d = (r == 12'd0) ? 12'($urandom_range(0, 80)) : 12'($urandom);
      rr = model_rounds(int'(r), int'(d));
      run_job(lvl, idx, z, r, d, int'($urandom_range(0, 3)), 1'b0);
      checks++; if (obs_n_r !== 12'(rr) || obs_n_d !== d) begin
        fails++; $display("FAIL random%0d n_r/n_d: got %0d/%0d want %0d/%0d", j, obs_n_r, obs_n_d, rr, d); end
      checks++; if (obs_n_level !== lvl || obs_n_index !== idx || obs_n_z !== z || obs_n_M !== job_M) begin
        fails++; $display("FAIL random%0d n_fields: got %h/%h/%h want %h/%h/%h", j, obs_n_level, obs_n_index, obs_n_z, lvl, idx, z); end
      checks++; if (step_cnt != 16 * rr || seq_err != 0 || excl_err != 0 || valid_cycle != 16 * rr + 3) begin
        fails++; $display("FAIL random%0d timing: got steps=%0d lat=%0d seqerr=%0d want %0d %0d 0", j, step_cnt, valid_cycle, seq_err, 16 * rr, 16 * rr + 3); end
      checks++; if (obs_C !== exp_C || obs_out_level !== lvl || obs_out_index !== idx) begin
        fails++; $display("FAIL random%0d result: got C=%h lvl=%h want C=%h lvl=%h", j, obs_C[63:0], obs_out_level, exp_C[63:0], lvl); end
      checks++; if (stab_err != 0 || valid_after !== 1'b0 || ready_after !== 1'b1) begin
        fails++; $display("FAIL random%0d handshake: got unstable=%0d valid=%b ready=%b want 0 0 1", j, stab_err, valid_after, ready_after); end
    end
  endtask

  initial begin
    test_reset();
    test_default_rounds();
    test_explicit_rounds();
    test_field_capture();
    test_back_to_back();
    test_reset_mid_run();
    test_random_jobs();
    test_max_rounds();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
